// File: rtl/contador_descendente_if.sv
// Handshake/data bundle for the loadable down counter: load request and
// pause in, registered count and status out.
interface contador_descendente_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] carga;
  logic             pausa;
  logic [WIDTH-1:0] cont;
  logic             ocupado;
  logic             fin;

  modport master (
    output start, carga, pausa,
    input  cont, ocupado, fin
  );

  modport slave (
    input  start, carga, pausa,
    output cont, ocupado, fin
  );
endinterface

// File: rtl/contador_descendente.sv
// Loadable down counter with prescaled decrement ticks, pause and a one-cycle
// completion pulse; every output comes straight from a register.
module contador_descendente #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  contador_descendente_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cont_q, cont_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             ocupado_q, ocupado_d;
  logic             fin_q, fin_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cont_q    <= '0;
      presc_q   <= '0;
      ocupado_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cont_q    <= cont_d;
      presc_q   <= presc_d;
      ocupado_q <= ocupado_d;
      fin_q     <= fin_d;
    end
  end

  // Completion is taken on the 1->0 step, so the count can never wrap.
  always_comb begin
    state_d   = state_q;
    cont_d    = cont_q;
    presc_d   = presc_q;
    ocupado_d = ocupado_q;
    fin_d     = 1'b0;
    case (state_q)
      IDLE: begin
        ocupado_d = 1'b0;
        if (bus.start) begin
          cont_d  = bus.carga;
          presc_d = '0;
          if (bus.carga != '0) begin
            state_d   = RUN;
            ocupado_d = 1'b1;
          end else begin
            state_d = DONE;
            fin_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (!bus.pausa) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            cont_d  = cont_q - WIDTH'(1);
            if (cont_q == WIDTH'(1)) begin
              state_d   = DONE;
              ocupado_d = 1'b0;
              fin_d     = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        ocupado_d = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        ocupado_d = 1'b0;
      end
    endcase
  end

  assign bus.cont    = cont_q;
  assign bus.ocupado = ocupado_q;
  assign bus.fin     = fin_q;

endmodule

// File: tb/tb_contador_descendente.sv
// Bench for contador_descendente: PRESCALE=1 and PRESCALE=3 instances share
// one stimulus stream and are compared against an elapsed-cycle model.
module tb_contador_descendente;

  logic       clock;
  logic       reset;
  logic       startV;
  logic [3:0] cargaV;
  logic       pausaV;

  int vectors = 0;
  int miscompares = 0;

  // Model state per instance: 0 idle, 1 running, 2 done.
  int mode[2] = '{0, 0};
  int nLoad[2] = '{0, 0};
  int active[2] = '{0, 0};
  int expCont[2] = '{0, 0};
  int presc[2] = '{1, 3};

  contador_descendente_if #(.WIDTH(4)) busA ();
  contador_descendente_if #(.WIDTH(4)) busB ();

  assign busA.start = startV;
  assign busA.carga = cargaV;
  assign busA.pausa = pausaV;
  assign busB.start = startV;
  assign busB.carga = cargaV;
  assign busB.pausa = pausaV;

  contador_descendente #(.WIDTH(4), .PRESCALE(1)) dutA (
    .clock(clock),
    .reset(reset),
    .bus  (busA)
  );

  contador_descendente #(.WIDTH(4), .PRESCALE(3)) dutB (
    .clock(clock),
    .reset(reset),
    .bus  (busB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count is the load value minus completed ticks, where ticks are unpaused
  // cycles since the load divided by the prescale factor.
  task automatic modelStep(input int d);
    if (reset) begin
      mode[d] = 0;
      expCont[d] = 0;
    end else begin
      case (mode[d])
        0: if (startV) begin
          nLoad[d] = int'(cargaV);
          active[d] = 0;
          expCont[d] = nLoad[d];
          mode[d] = (nLoad[d] == 0) ? 2 : 1;
        end
        1: begin
          if (!pausaV) active[d]++;
          expCont[d] = nLoad[d] - active[d] / presc[d];
          if (active[d] == nLoad[d] * presc[d]) mode[d] = 2;
        end
        default: mode[d] = 0;
      endcase
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input int exp);
    vectors++;
    assert (obs === 32'(exp))
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("A.cont", 32'(busA.cont), expCont[0]);
    checkVal("A.ocupado", 32'(busA.ocupado), (mode[0] == 1) ? 1 : 0);
    checkVal("A.fin", 32'(busA.fin), (mode[0] == 2) ? 1 : 0);
    checkVal("B.cont", 32'(busB.cont), expCont[1]);
    checkVal("B.ocupado", 32'(busB.ocupado), (mode[1] == 1) ? 1 : 0);
    checkVal("B.fin", 32'(busB.fin), (mode[1] == 2) ? 1 : 0);
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [3:0] c, input logic p);
    reset = r;
    startV = s;
    cargaV = c;
    pausaV = p;
    @(posedge clock);
    modelStep(0);
    modelStep(1);
    #1;
    checkOutput();
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 80; i++) begin
      if (mode[0] == 0 && mode[1] == 0) break;
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    int cyc;
    bit seen;
    bit finSeen;
    reset = 1'b1;
    startV = 1'b1;
    cargaV = 4'd9;
    pausaV = 1'b0;
    #1;

    $display("[TB] reset held with start asserted");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 4'd9, 1'b0);

    $display("[TB] load 5 on the first edge after reset release");
    applyStimulus(1'b0, 1'b1, 4'd5, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    waitIdle();

    $display("[TB] zero load goes straight to completion");
    applyStimulus(1'b0, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);

    $display("[TB] prescale 3, load 2, pause after first decrement");
    applyStimulus(1'b0, 1'b1, 4'd2, 1'b0);
    cyc = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd2, (i >= 4 && i <= 7));
      if (busB.fin === 1'b1) begin
        seen = 1'b1;
        cyc = i;
      end
    end
    checkVal("B.finLatency", 32'(cyc), 10);
    waitIdle();

    $display("[TB] start ignored mid-run and during completion");
    applyStimulus(1'b0, 1'b1, 4'd4, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd15, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd15, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd3, 1'b0);
    checkVal("A.reloadFromIdle", 32'(busA.cont), 3);
    waitIdle();

    $display("[TB] reset in the middle of a max-value run");
    applyStimulus(1'b0, 1'b1, 4'd15, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkVal("A.contBeforeReset", 32'(busA.cont), 7);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    finSeen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
      if (busA.fin !== 1'b0 || busB.fin !== 1'b0) finSeen = 1'b1;
    end
    checkVal("noFinAfterReset", 32'(finSeen), 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) == 0),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/contador_descendente.md
Name: contador_descendente

Overview:
Loadable down counter. It is the counterpart to the team's free-running 4-bit up counter: it counts toward zero instead of away from it. A start strobe loads a value, the counter decrements on prescaled ticks, and it signals completion with a one-cycle `fin` pulse. It is used as the timeout/delay element beside the up counter in the same clock domain.

Parameters:
- WIDTH, 4, width of the load value and of the count output.
- PRESCALE, 1, clock cycles per decrement tick. Must be >= 1; 1 means decrement every cycle.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  load/start request; sampled only in IDLE.
- carga  input  WIDTH  start value, captured when start is accepted.
- pausa  input  1  freezes the count and the prescaler while high (RUN only).
- cont  output  WIDTH  current count, registered.
- ocupado  output  1  high while in RUN.
- fin  output  1  one-cycle completion pulse, high in DONE.

Behaviour:
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset (synchronous, dominates everything):
  - cont=0, ocupado=0, fin=0, state=IDLE, prescaler=0.
  - Applies mid-RUN or mid-DONE with no completion pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: cont<=carga, prescaler<=0.
  - If carga!=0: go to RUN, ocupado=1 after edge k.
  - If carga==0: go straight to DONE, fin=1 after edge k.
  - start=0: hold. cont keeps its last value, which is 0 after any completed run.
- RUN:
  - tick = (prescaler==PRESCALE-1) && !pausa.
  - pausa=0 and no tick: prescaler increments.
  - On tick: prescaler<=0, cont<=cont-1.
  - If cont==1 on tick: cont<=0, state<=DONE, ocupado<=0, fin<=1.
  - pausa=1: cont and prescaler hold, state holds, ocupado stays 1.
  - start in RUN is ignored (no restart, no reload).
- DONE:
  - Lasts exactly one cycle: fin=1, cont=0.
  - Next edge: fin<=0, state<=IDLE.
  - start during DONE is ignored; it is accepted from IDLE on the following cycle at the earliest.
- Latency with PRESCALE=P and load N>0 accepted at edge k (no pausa):
  - cont reaches 0 and fin rises after edge k+N*P.
  - fin falls after edge k+N*P+1.
  - Back-to-back minimum period is N*P+2 cycles.
- Arithmetic:
  - Unsigned decrement. cont never wraps below 0, because the transition to DONE happens at 1->0.
  - The prescaler uses ceil(log2(PRESCALE)) bits, minimum 1 bit.
  - The full carga range 0..2^WIDTH-1 is legal.
- Simultaneous events:
  - reset beats start/pausa.
  - pausa beats tick.
  - pausa has no effect in IDLE or DONE.

Test Plan:
- Reset with start=1 held, then release: cont=0, ocupado=0, fin=0 during reset. Load happens only on the first edge after reset drops.
- PRESCALE=1, carga=5, start pulsed at edge k:
  - cont=5,4,3,2,1,0 after edges k..k+5.
  - ocupado=1 after edges k..k+4.
  - fin=1 only after edge k+5; IDLE after k+6.
- carga=0 start: after edge k, fin=1, ocupado never rises, cont=0. Back in IDLE after k+1.
- PRESCALE=3, carga=2, pausa high for 4 cycles after the first decrement:
  - cont=2 for 3 cycles, then 1 for 3+4 cycles, then 0.
  - fin at total cycle 3+7=10 after load.
- start re-asserted mid-RUN with carga=15 and again during the DONE cycle: both ignored. The count completes from the original value, and the next load is accepted only in IDLE.
- carga=15 (max), reset asserted when cont=7: cont=0, ocupado=0 next edge, and no fin pulse is ever produced.
